joy_db15_tx: RTL and testbench



---
 rtl/joy_db15_pkg.sv | 30 +++
 rtl/joy_db15_tx_sync.sv | 35 +++
 rtl/joy_db15_tx.sv | 135 +++++++++++++
 tb/tb_joy_db15_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 joystick link: FSM states, frame size
// and button bit positions within a player word.
package joy_db15_pkg;

    // Link responder states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } joy_state_e;

    localparam int PLAYER_BITS_DEF = 12;
    localparam int FRAME_BITS      = 2 * PLAYER_BITS_DEF;

    // Bit positions of each button inside a player word (active-high).
    localparam int BTN_R     = 0;
    localparam int BTN_L     = 1;
    localparam int BTN_D     = 2;
    localparam int BTN_U     = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_X     = 7;
    localparam int BTN_Y     = 8;
    localparam int BTN_Z     = 9;
    localparam int BTN_START = 10;
    localparam int BTN_MODE  = 11;

endpackage

// File: rtl/joy_db15_tx_sync.sv
// N-stage synchroniser for an asynchronous host line, plus a history flop
// that yields single-cycle rise/fall pulses on the synchronised level.
module joy_sync_edge
    import joy_db15_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;

    // Shift the raw line through the synchroniser and keep one cycle of history.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
            hist  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            hist  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~hist;
    assign fall  = ~level & hist;

endmodule

// File: rtl/joy_db15_tx.sv
// Device-side responder for the DB15 serial joystick link. Behaves like a
// chained 74HC165: a low joy_load captures both players' buttons (inverted,
// 0 = pressed), each joy_clk rise shifts the next bit onto joy_data and 1s
// fill in behind. Optional link watchdog: JOY_DB15_TX_WATCHDOG_EN.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int          PLAYER_BITS = 12,
    parameter int          SYNC_STAGES = 2,
    parameter logic [23:0] WDOG_CYCLES = 24'd4800000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   joy_clk,
    input  logic                   joy_load,
    output logic                   joy_data,
    input  logic [PLAYER_BITS-1:0] joystick1,
    input  logic [PLAYER_BITS-1:0] joystick2,
    output logic                   frame_done,
    output logic                   link_ok
);

    localparam int             FB       = 2 * PLAYER_BITS;
    localparam int             CW       = $clog2(FB);
    localparam logic [CW-1:0]  PRE_LAST = CW'(FB - 2);

    logic unused_clk_level, unused_clk_fall;
    logic clk_rise, load_level, load_rise, load_fall, load_low;
    logic force_idle;

    joy_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_clk_sync (
        .clk(clk), .reset(reset), .din(joy_clk),
        .level(unused_clk_level), .rise(clk_rise), .fall(unused_clk_fall)
    );

    // joy_load idles high, so its synchroniser resets high to avoid a false load.
    joy_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_load_sync (
        .clk(clk), .reset(reset), .din(joy_load),
        .level(load_level), .rise(load_rise), .fall(load_fall)
    );

    assign load_low = ~load_level;

    joy_state_e     state, state_next;
    logic [FB-1:0]  sr, sr_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic           frame_pulse, fd_pend;

    // Next-state logic: a low load beats everything, then the watchdog, then shifting.
    always_comb begin
        state_next  = state;
        sr_next     = sr;
        cnt_next    = cnt;
        frame_pulse = 1'b0;
        if (load_low) begin
            state_next = LOADING;
            sr_next    = ~{joystick2, joystick1};
            cnt_next   = '0;
        end else if (force_idle) begin
            state_next = IDLE;
            sr_next    = '1;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    sr_next = '1;
                end
                LOADING: begin
                    if (load_rise) state_next = SHIFT;
                end
                SHIFT: begin
                    if (clk_rise) begin
                        sr_next  = {1'b1, sr[FB-1:1]};
                        cnt_next = cnt + 1'b1;
                        if (cnt == PRE_LAST) begin
                            frame_pulse = 1'b1;
                            state_next  = DONE;
                        end
                    end
                end
                DONE: begin
                    // Counter stays saturated; only 1s come out from here on.
                    if (clk_rise) sr_next = {1'b1, sr[FB-1:1]};
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, shift register and the output stage; frame_done is delayed to line up with joy_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sr         <= '1;
            cnt        <= '0;
            fd_pend    <= 1'b0;
            joy_data   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            sr         <= sr_next;
            cnt        <= cnt_next;
            fd_pend    <= frame_pulse;
            joy_data   <= sr[0];
            frame_done <= fd_pend;
        end
    end

`ifdef JOY_DB15_TX_WATCHDOG_EN
    logic [23:0] wd_cnt;
    logic        seen_load;

    // Cycles since the last load fall; saturates so a dead host stays dead.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt    <= '0;
            seen_load <= 1'b0;
        end else if (load_fall) begin
            wd_cnt    <= '0;
            seen_load <= 1'b1;
        end else if (wd_cnt != '1) begin
            wd_cnt    <= wd_cnt + 24'd1;
        end
    end

    assign force_idle = (wd_cnt >= WDOG_CYCLES);
    assign link_ok    = seen_load & ~force_idle;
`else
    logic unused_wdog;
    assign unused_wdog = ^{WDOG_CYCLES, load_fall};
    assign force_idle  = 1'b0;
    assign link_ok     = 1'b1;
`endif

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: random two-player frames, oversized frames, load
// abort, mid-frame reset and idle behaviour, checked against a bit-queue
// model of the frame. Watchdog section only when JOY_DB15_TX_WATCHDOG_EN.
module tb_joy_db15_tx;

    localparam int SYNC = 2;
`ifdef JOY_DB15_TX_WATCHDOG_EN
    localparam logic LINK_RESET = 1'b0;
`else
    localparam logic LINK_RESET = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        joy_clk = 1'b0;
    logic        joy_load = 1'b1;
    logic        joy_data, frame_done, link_ok;
    logic [11:0] joystick1 = '0;
    logic [11:0] joystick2 = '0;

    int errors = 0;
    int checks = 0;
    int fd_count = 0;
    int exp_fd = 0;
    logic [0:0] exp_q[$];

    joy_db15_tx #(.PLAYER_BITS(12), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .joy_clk(joy_clk), .joy_load(joy_load),
        .joy_data(joy_data), .joystick1(joystick1), .joystick2(joystick2),
        .frame_done(frame_done), .link_ok(link_ok)
    );

`ifdef JOY_DB15_TX_WATCHDOG_EN
    logic joy_load_wd = 1'b1;
    logic joy_data_wd, frame_done_wd, link_ok_wd;
    logic [11:0] js_wd = 12'hFFF;

    joy_db15_tx #(.PLAYER_BITS(12), .SYNC_STAGES(SYNC), .WDOG_CYCLES(24'd100)) dut_wd (
        .clk(clk), .reset(reset), .joy_clk(1'b0), .joy_load(joy_load_wd),
        .joy_data(joy_data_wd), .joystick1(js_wd), .joystick2(js_wd),
        .frame_done(frame_done_wd), .link_ok(link_ok_wd)
    );
`endif

    // clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) if (frame_done) fd_count++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // model: next bit the host should see; 1 once the frame is exhausted
    task automatic pop_expected(output logic b);
        if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            if (exp_q.size() == 0) exp_fd++;
        end else begin
            b = 1'b1;
        end
    endtask

    task automatic start_load(input logic [11:0] j1, input logic [11:0] j2);
        logic [23:0] w;
        w = {j2, j1};
        joystick1 = j1;
        joystick2 = j2;
        joy_load  = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 24; k++) exp_q.push_back(~w[k]);
    endtask

    task automatic finish_load(input string tag);
        logic b;
        tick(8);
        pop_expected(b);
        check({tag, "_bit0"}, joy_data, b);
        check({tag, "_fd_load"}, fd_count, exp_fd);
        joy_load = 1'b1;
        tick(8);
    endtask

    task automatic shift_bits(input int n, input string tag);
        logic b;
        for (int i = 0; i < n; i++) begin
            joy_clk   = 1'b1;
            joystick1 = 12'($urandom_range(0, 4095));
            joystick2 = 12'($urandom_range(0, 4095));
            pop_expected(b);
            tick(7);
            check({tag, "_bit"}, joy_data, b);
            check({tag, "_fd"}, fd_count, exp_fd);
            tick(1);
            joy_clk = 1'b0;
            tick(8);
        end
    endtask

    initial begin
        logic [11:0] a, c;

        // reset state
        tick(4);
        check("rst_data", joy_data, 1'b1);
        check("rst_fd", frame_done, 1'b0);
        check("rst_link", link_ok, LINK_RESET);
        reset = 1'b0;

        // idle: host clocks without a load are ignored
        for (int i = 0; i < 1000; i++) begin
            if (i % 8 == 0) joy_clk = ~joy_clk;
            tick(1);
            if (i % 125 == 124) check("idle_data", joy_data, 1'b1);
        end
        joy_clk = 1'b0;
        tick(8);
        check("idle_fd", fd_count, 0);

        // directed corner pattern: only first and last frame bits pressed
        start_load(12'h001, 12'h800);
        finish_load("dir");
        shift_bits(24, "dir");
        check("link_after_load", link_ok, 1'b1);

        // random frames, some clocked well past the end of the frame
        for (int f = 0; f < 4; f++) begin
            a = 12'($urandom_range(0, 4095));
            c = 12'($urandom_range(0, 4095));
            start_load(a, c);
            finish_load("rnd");
            shift_bits((f == 0) ? 30 : 23 + $urandom_range(0, 6), "rnd");
        end

        // load coincident with a clock rise at bit 10 aborts the frame
        start_load(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        finish_load("abort_pre");
        shift_bits(10, "abort_pre");
        joy_clk = 1'b1;
        a = 12'($urandom_range(0, 4095));
        c = 12'($urandom_range(0, 4095));
        start_load(a, c);
        finish_load("abort");
        joy_clk = 1'b0;
        tick(8);
        shift_bits(26, "abort_new");

        // reset at bit 7: data high next cycle, clocks ignored afterwards
        start_load(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        finish_load("rst_mid_pre");
        shift_bits(7, "rst_mid_pre");
        reset = 1'b1;
        tick(1);
        check("rst_mid_data", joy_data, 1'b1);
        check("rst_mid_fd", frame_done, 1'b0);
        reset = 1'b0;
        exp_q.delete();
        shift_bits(5, "rst_mid_idle");

`ifdef JOY_DB15_TX_WATCHDOG_EN
        // watchdog: regular loads keep the link up, silence drops it after 100 cycles
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check("wd_rst_link", link_ok_wd, 1'b0);
        for (int i = 0; i < 6; i++) begin
            joy_load_wd = 1'b0;
            tick(8);
            joy_load_wd = 1'b1;
            tick(42);
            check("wd_alive", link_ok_wd, 1'b1);
        end
        joy_load_wd = 1'b0;
        for (int n = 1; n <= SYNC + 106; n++) begin
            tick(1);
            if (n == 8) joy_load_wd = 1'b1;
            if (n == SYNC + 100) begin
                check("wd_link_before", link_ok_wd, 1'b1);
                check("wd_data_before", joy_data_wd, 1'b0);
            end
            if (n == SYNC + 101) check("wd_link_drop", link_ok_wd, 1'b0);
            if (n == SYNC + 106) check("wd_data_idle", joy_data_wd, 1'b1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
